mem_wb_stage: RTL and testbench

- MEM stage plus MEM/WB pipeline register of the 5-stage MIPS pipeline; consumes the EX/MEM register outputs.
- Resolves branch/jump redirects and drives the flush into upstream pipeline registers.
- Performs data-memory loads/stores over a req/ack handshake, stalling upstream while an access is outstanding.
- Registers writeback controls and data for the WB stage.

---
 rtl/mem_wb_stage.sv | 107 ++++++++++
 tb/tb_mem_wb_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register: data-memory access over a req/ack
// handshake with timeout, branch/jump redirect, and writeback register.
module mem_wb_stage #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  decoder_i,
  input  logic [31:0] PC_plus4_i,
  input  logic        zero_i,
  input  logic [31:0] FURslt_i,
  input  logic [31:0] ReadData2_i,
  input  logic [4:0]  instruction_i,
  input  logic [31:0] jump_addr_i,
  input  logic        jump_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] redirect_pc_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] MemData_o,
  output logic [31:0] ALUrslt_o,
  output logic [4:0]  WriteReg_o,
  output logic [31:0] WBdata_o,
  output logic        err_o
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             memop;
  logic             timeout_hit;
  logic             done;
  logic             redirect_req;

  // done: the instruction in MEM retires at the coming edge
  always_comb begin
    memop        = decoder_i[1] | decoder_i[0];
    timeout_hit  = (state == ACCESS) && !dmem_ack_i && (cnt == CNT_W'(TIMEOUT - 1));
    done         = (state == IDLE) ? !memop : (dmem_ack_i || timeout_hit);
    redirect_req = jump_i | (decoder_i[2] & zero_i);
    stall_o      = !rst_i && !done;
    // a redirect on a memop is deferred until the access retires
    flush_o       = !rst_i && done && redirect_req;
    redirect_pc_o = flush_o ? (jump_i ? jump_addr_i : PC_plus4_i) : 32'd0;
  end

  assign WBdata_o = MemtoReg_o ? MemData_o : ALUrslt_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= 32'd0;
      dmem_wdata_o <= 32'd0;
      RegWrite_o   <= 1'b0;
      MemtoReg_o   <= 1'b0;
      MemData_o    <= 32'd0;
      ALUrslt_o    <= 32'd0;
      WriteReg_o   <= 5'd0;
      err_o        <= 1'b0;
    end else begin
      if (done) begin
        RegWrite_o <= decoder_i[4];
        MemtoReg_o <= decoder_i[3];
        ALUrslt_o  <= FURslt_i;
        WriteReg_o <= instruction_i;
        MemData_o  <= (state == ACCESS && dmem_ack_i && !dmem_we_o) ? dmem_rdata_i : 32'd0;
      end else begin
        RegWrite_o <= 1'b0;
        MemtoReg_o <= 1'b0;
        ALUrslt_o  <= 32'd0;
        WriteReg_o <= 5'd0;
        MemData_o  <= 32'd0;
      end

      if (state == IDLE) begin
        if (memop) begin
          dmem_req_o   <= 1'b1;
          dmem_we_o    <= decoder_i[0];
          dmem_addr_o  <= FURslt_i;
          dmem_wdata_o <= ReadData2_i;
          cnt          <= '0;
          state        <= ACCESS;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (dmem_ack_i || timeout_hit) begin
          dmem_req_o <= 1'b0;
          state      <= IDLE;
          if (timeout_hit) err_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed literal cases, then randomized traffic
// against a transaction-level reference model with a random-latency memory.
module tb_mem_wb_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [4:0]  decoder_i;
  logic [31:0] PC_plus4_i;
  logic        zero_i;
  logic [31:0] FURslt_i;
  logic [31:0] ReadData2_i;
  logic [4:0]  instruction_i;
  logic [31:0] jump_addr_i;
  logic        jump_i;
  logic        stall_o, flush_o;
  logic [31:0] redirect_pc_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;
  logic        RegWrite_o, MemtoReg_o;
  logic [31:0] MemData_o, ALUrslt_o, WBdata_o;
  logic [4:0]  WriteReg_o;
  logic        err_o;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  mem_wb_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .decoder_i(decoder_i), .PC_plus4_i(PC_plus4_i),
    .zero_i(zero_i), .FURslt_i(FURslt_i), .ReadData2_i(ReadData2_i),
    .instruction_i(instruction_i), .jump_addr_i(jump_addr_i), .jump_i(jump_i),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemData_o(MemData_o),
    .ALUrslt_o(ALUrslt_o), .WriteReg_o(WriteReg_o), .WBdata_o(WBdata_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_busy;      // an access is outstanding
  int          m_waited;    // memory cycles already spent on it
  bit          m_req, m_we, m_rw, m_m2r, m_err;
  logic [31:0] m_addr, m_wdata, m_md, m_alu;
  logic [4:0]  m_wr;

  task automatic model_clear();
    m_busy = 0; m_waited = 0; m_req = 0; m_we = 0; m_rw = 0; m_m2r = 0; m_err = 0;
    m_addr = 0; m_wdata = 0; m_md = 0; m_alu = 0; m_wr = 0;
  endtask

  initial model_clear();

  always @(negedge clk) begin
    bit is_mem, retire, gave_up, redir;
    logic [31:0] e_pc;
    if (mon_en) begin
      chk("dmem_req", dmem_req_o, m_req);
      chk("dmem_we", dmem_we_o, m_we);
      chk("dmem_addr", dmem_addr_o, m_addr);
      chk("dmem_wdata", dmem_wdata_o, m_wdata);
      chk("RegWrite", RegWrite_o, m_rw);
      chk("MemtoReg", MemtoReg_o, m_m2r);
      chk("MemData", MemData_o, m_md);
      chk("ALUrslt", ALUrslt_o, m_alu);
      chk("WriteReg", WriteReg_o, m_wr);
      chk("WBdata", WBdata_o, m_m2r ? m_md : m_alu);
      chk("err", err_o, m_err);

      is_mem  = decoder_i[1] || decoder_i[0];
      gave_up = m_busy && !dmem_ack_i && (m_waited + 1 >= TO);
      retire  = m_busy ? (dmem_ack_i || gave_up) : !is_mem;
      redir   = jump_i || (decoder_i[2] && zero_i);
      e_pc    = jump_i ? jump_addr_i : PC_plus4_i;
      chk("stall", stall_o, !rst_i && !retire);
      chk("flush", flush_o, !rst_i && retire && redir);
      chk("redirect_pc", redirect_pc_o, (!rst_i && retire && redir) ? e_pc : 32'd0);

      if (rst_i) model_clear();
      else begin
        if (retire) begin
          m_rw = decoder_i[4]; m_m2r = decoder_i[3]; m_alu = FURslt_i; m_wr = instruction_i;
          m_md = (m_busy && dmem_ack_i && !m_we) ? dmem_rdata_i : 32'd0;
        end else begin
          m_rw = 0; m_m2r = 0; m_alu = 0; m_wr = 0; m_md = 0;
        end
        if (!m_busy && is_mem) begin
          m_busy = 1; m_waited = 0; m_req = 1;
          m_we = decoder_i[0]; m_addr = FURslt_i; m_wdata = ReadData2_i;
        end else if (m_busy) begin
          if (retire) begin
            m_busy = 0; m_req = 0;
            if (gave_up) m_err = 1;
          end else m_waited++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [4:0] d, input logic [31:0] fur, input logic [31:0] rd2,
                       input logic [4:0] wr, input logic [31:0] pc4, input logic z,
                       input logic j, input logic [31:0] ja);
    decoder_i = d; FURslt_i = fur; ReadData2_i = rd2; instruction_i = wr;
    PC_plus4_i = pc4; zero_i = z; jump_i = j; jump_addr_i = ja;
  endtask

  task automatic nop();
    drive(5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit prev_stall, prev_flush, in_req;
    int seen, lat;
    rst_i = 1'b1; dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0;
    nop();
    tick(); tick();
    mon_en = 1'b1;
    #1;
    chk("rst_req", dmem_req_o, 32'd0);
    chk("rst_regwrite", RegWrite_o, 32'd0);
    chk("rst_wbdata", WBdata_o, 32'd0);
    chk("rst_err", err_o, 32'd0);
    chk("rst_stall", stall_o, 32'd0);
    tick();
    rst_i = 1'b0;

    // ALU op
    drive(5'b10000, 32'h10, 32'd0, 5'd8, 32'd0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("alu_stall", stall_o, 32'd0);
    chk("alu_flush", flush_o, 32'd0);
    tick(); #1;
    chk("alu_regwrite", RegWrite_o, 32'd1);
    chk("alu_wbdata", WBdata_o, 32'h10);
    chk("alu_writereg", WriteReg_o, 32'd8);
    chk("alu_req", dmem_req_o, 32'd0);

    // branch taken, jump priority, branch not taken
    drive(5'b00100, 32'd0, 32'd0, 5'd0, 32'h40, 1'b1, 1'b0, 32'd0);
    #1;
    chk("br_flush", flush_o, 32'd1);
    chk("br_pc", redirect_pc_o, 32'h40);
    jump_i = 1'b1; jump_addr_i = 32'h80;
    #1;
    chk("jmp_pc", redirect_pc_o, 32'h80);
    jump_i = 1'b0; zero_i = 1'b0;
    #1;
    chk("br_nt_flush", flush_o, 32'd0);
    chk("br_nt_pc", redirect_pc_o, 32'd0);
    tick();

    // load, ack in the third memory cycle
    drive(5'b11010, 32'h100, 32'd0, 5'd3, 32'd0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("ld_stall0", stall_o, 32'd1);
    tick(); #1;
    chk("ld_req", dmem_req_o, 32'd1);
    chk("ld_addr", dmem_addr_o, 32'h100);
    chk("ld_we", dmem_we_o, 32'd0);
    chk("ld_stall1", stall_o, 32'd1);
    chk("ld_bubble", RegWrite_o, 32'd0);
    tick(); #1;
    chk("ld_stall2", stall_o, 32'd1);
    tick();
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("ld_ack_stall", stall_o, 32'd0);
    tick();
    dmem_ack_i = 1'b0; nop();
    #1;
    chk("ld_memdata", MemData_o, 32'hDEADBEEF);
    chk("ld_wbdata", WBdata_o, 32'hDEADBEEF);
    chk("ld_regwrite", RegWrite_o, 32'd1);
    chk("ld_req_drop", dmem_req_o, 32'd0);

    // store, ack on the first memory cycle
    drive(5'b00001, 32'h20, 32'h1234, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    dmem_ack_i = 1'b1;
    #1;
    chk("st_we", dmem_we_o, 32'd1);
    chk("st_wdata", dmem_wdata_o, 32'h1234);
    chk("st_stall", stall_o, 32'd0);
    tick();
    dmem_ack_i = 1'b0; nop();
    #1;
    chk("st_regwrite", RegWrite_o, 32'd0);
    chk("st_memdata", MemData_o, 32'd0);

    // load timeout: four stall cycles, then retire with error
    drive(5'b11010, 32'h200, 32'd0, 5'd4, 32'd0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_stall", stall_o, 32'd1);
      tick();
    end
    #1;
    chk("to_release", stall_o, 32'd0);
    chk("to_err_pre", err_o, 32'd0);
    tick();
    nop();
    #1;
    chk("to_err", err_o, 32'd1);
    chk("to_memdata", MemData_o, 32'd0);
    chk("to_regwrite", RegWrite_o, 32'd1);
    tick(); #1;
    chk("to_err_sticky", err_o, 32'd1);

    // reset in the middle of an access, then a late ack
    drive(5'b11010, 32'h300, 32'd0, 5'd5, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; nop(); dmem_ack_i = 1'b1; dmem_rdata_i = 32'h55AA55AA;
    #1;
    chk("mr_req", dmem_req_o, 32'd0);
    chk("mr_err", err_o, 32'd0);
    chk("mr_wbdata", WBdata_o, 32'd0);
    chk("mr_stall", stall_o, 32'd0);
    tick();
    dmem_ack_i = 1'b0;
    #1;
    chk("mr_late_ack", MemData_o, 32'd0);
    chk("mr_late_req", dmem_req_o, 32'd0);

    // randomized traffic with a random-latency memory
    prev_stall = 0; prev_flush = 0; in_req = 0; seen = 0; lat = 1;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      prev_stall = stall_o;
      prev_flush = flush_o;
      tick();
      rst_i = ($urandom_range(0, 199) == 0);
      if (!prev_stall) begin
        if (prev_flush) nop();
        else drive(5'($urandom), $urandom, $urandom, 5'($urandom), $urandom,
                   1'($urandom), ($urandom_range(0, 3) == 0), $urandom);
      end
      dmem_rdata_i = $urandom;
      if (dmem_req_o) begin
        if (!in_req) begin
          in_req = 1; seen = 0; lat = $urandom_range(1, TO + 1);
        end
        seen++;
        dmem_ack_i = (seen == lat);
      end else begin
        in_req = 0;
        dmem_ack_i = ($urandom_range(0, 7) == 0);
      end
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
